// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the IF/DEC/EXE datapath and the pipeline sequencing controller.
// The datapath side is the master; pipe_ctrl is the slave.
interface pipe_ctrl_if;
    logic       dec_instr_v_i;
    logic       dec_rs1_v_i;
    logic [4:0] dec_rs1_adr_i;
    logic       dec_rs2_v_i;
    logic [4:0] dec_rs2_adr_i;
    logic       dec_mc_v_i;
    logic       exe_load_v_q_i;
    logic [4:0] exe_rd_adr_q_i;
    logic       mc_done_i;
    logic       flush_req_i;
    logic       stall_if_o;
    logic       stall_dec_o;
    logic       bubble_exe_o;
    logic       mc_start_o;
    logic       mc_abort_o;
    logic       flush_v_q_o;
    logic       wdog_err_q_o;

    modport master (
        output dec_instr_v_i, dec_rs1_v_i, dec_rs1_adr_i, dec_rs2_v_i, dec_rs2_adr_i,
        output dec_mc_v_i, exe_load_v_q_i, exe_rd_adr_q_i, mc_done_i, flush_req_i,
        input  stall_if_o, stall_dec_o, bubble_exe_o, mc_start_o, mc_abort_o,
        input  flush_v_q_o, wdog_err_q_o
    );

    modport slave (
        input  dec_instr_v_i, dec_rs1_v_i, dec_rs1_adr_i, dec_rs2_v_i, dec_rs2_adr_i,
        input  dec_mc_v_i, exe_load_v_q_i, exe_rd_adr_q_i, mc_done_i, flush_req_i,
        output stall_if_o, stall_dec_o, bubble_exe_o, mc_start_o, mc_abort_o,
        output flush_v_q_o, wdog_err_q_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stall, multi-cycle unit start/done/watchdog
// sequencing, and the registered flush pulse train that follows a redirect.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MC_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    pipe_ctrl_if.slave pif
);
    localparam int unsigned FCW = 4;
    localparam int unsigned MCW = 8;
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [MCW-1:0] MC_LAST      = MCW'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MC_WAIT  = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [MCW-1:0] mc_cnt_q, mc_cnt_d;
    logic           flush_v_q, flush_v_d;
    logic           wdog_err_q, wdog_err_d;

    logic rs1_hit, rs2_hit, load_hazard, mc_issue;
    logic stall_c, start_c, abort_c;

    // x0 is hardwired zero, so a load targeting it never produces a dependency.
    assign rs1_hit     = pif.dec_rs1_v_i & (pif.dec_rs1_adr_i == pif.exe_rd_adr_q_i);
    assign rs2_hit     = pif.dec_rs2_v_i & (pif.dec_rs2_adr_i == pif.exe_rd_adr_q_i);
    assign load_hazard = pif.dec_instr_v_i & pif.exe_load_v_q_i &
                         (pif.exe_rd_adr_q_i != 5'd0) & (rs1_hit | rs2_hit);
    assign mc_issue    = pif.dec_instr_v_i & pif.dec_mc_v_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            mc_cnt_q    <= '0;
            flush_v_q   <= 1'b0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
            flush_v_q   <= flush_v_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        mc_cnt_d    = mc_cnt_q;
        flush_v_d   = flush_v_q;
        wdog_err_d  = wdog_err_q;
        stall_c     = 1'b0;
        start_c     = 1'b0;
        abort_c     = 1'b0;

        if (pif.flush_req_i) begin
            // Redirect wins over everything; an in-flight mc op is killed even if it just finished.
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
            flush_v_d   = 1'b1;
            abort_c     = (state_q == MC_WAIT);
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_hazard) begin
                        stall_c = 1'b1;
                        state_d = LD_STALL;
                    end else if (mc_issue) begin
                        start_c  = 1'b1;
                        mc_cnt_d = '0;
                        state_d  = MC_WAIT;
                    end
                end
                LD_STALL: begin
                    // Load data is on the RF fast-forward now, so DEC may issue.
                    state_d = RUN;
                end
                MC_WAIT: begin
                    if (mc_cnt_q == MC_LAST) begin
                        abort_c    = 1'b1;
                        wdog_err_d = 1'b1;
                        state_d    = RUN;
                    end else if (pif.mc_done_i) begin
                        state_d = RUN;
                    end else begin
                        stall_c  = 1'b1;
                        mc_cnt_d = mc_cnt_q + MCW'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        flush_v_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FCW'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign pif.stall_if_o   = reset_n & stall_c;
    assign pif.stall_dec_o  = reset_n & stall_c;
    assign pif.bubble_exe_o = reset_n & stall_c;
    assign pif.mc_start_o   = reset_n & start_c;
    assign pif.mc_abort_o   = reset_n & abort_c;
    assign pif.flush_v_q_o  = flush_v_q;
    assign pif.wdog_err_q_o = wdog_err_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: hazard vector table, hand-written multi-cycle
// sequences, then randomized traffic against a cycle-level reference model.
module tb_pipe_ctrl;
    localparam int FC = 2;
    localparam int MT = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if pif();

    pipe_ctrl #(.FLUSH_CYCLES(FC), .MC_TIMEOUT(MT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pif(pif)
    );

    typedef struct {
        logic       dv;
        logic       r1v;
        logic [4:0] r1;
        logic       r2v;
        logic [4:0] r2;
        logic       mcv;
        logic       ldv;
        logic [4:0] rd;
        logic       exp_stall;
        logic       exp_start;
    } vec_t;

    // Reference model state: cycles of flush left, age of in-flight mc op (-1 none),
    // one-cycle post-load shadow, sticky watchdog.
    int flush_left;
    int mc_age;
    bit ld_shadow;
    bit wdog_m;

    function automatic logic [6:0] outs();
        return {pif.stall_if_o, pif.stall_dec_o, pif.bubble_exe_o, pif.mc_start_o,
                pif.mc_abort_o, pif.flush_v_q_o, pif.wdog_err_q_o};
    endfunction

    function automatic logic [6:0] ex(logic st, logic go, logic ab, logic fv, logic wd);
        return {st, st, st, go, ab, fv, wd};
    endfunction

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic dv, input logic r1v, input logic [4:0] r1,
                          input logic r2v, input logic [4:0] r2, input logic mcv,
                          input logic ldv, input logic [4:0] rd);
        pif.dec_instr_v_i  = dv;
        pif.dec_rs1_v_i    = r1v;
        pif.dec_rs1_adr_i  = r1;
        pif.dec_rs2_v_i    = r2v;
        pif.dec_rs2_adr_i  = r2;
        pif.dec_mc_v_i     = mcv;
        pif.exe_load_v_q_i = ldv;
        pif.exe_rd_adr_q_i = rd;
    endtask

    task automatic clr_in();
        set_in(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0);
        pif.mc_done_i   = 1'b0;
        pif.flush_req_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr_in();
        tick();
        tick();
        reset_n = 1'b1;
        flush_left = 0;
        mc_age     = -1;
        ld_shadow  = 0;
        wdog_m     = 0;
    endtask

    function automatic bit model_hazard();
        bit h1, h2;
        h1 = pif.dec_rs1_v_i && (pif.dec_rs1_adr_i == pif.exe_rd_adr_q_i);
        h2 = pif.dec_rs2_v_i && (pif.dec_rs2_adr_i == pif.exe_rd_adr_q_i);
        return pif.dec_instr_v_i && pif.exe_load_v_q_i && (pif.exe_rd_adr_q_i != 0) && (h1 || h2);
    endfunction

    // Expected outputs for the current cycle from the model, then advance it one cycle.
    task automatic model_step(output logic [6:0] want);
        bit st, go, ab, fv, wd, wd_n;
        st = 0; go = 0; ab = 0;
        fv = (flush_left > 0);
        wd = wdog_m;
        wd_n = wdog_m;
        if (pif.flush_req_i) begin
            ab = (mc_age >= 0);
            flush_left = FC;
            mc_age = -1;
            ld_shadow = 0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (mc_age >= 0) begin
            if (mc_age == MT - 1) begin
                ab = 1; wd_n = 1; mc_age = -1;
            end else if (pif.mc_done_i) begin
                mc_age = -1;
            end else begin
                st = 1; mc_age++;
            end
        end else if (ld_shadow) begin
            ld_shadow = 0;
        end else if (model_hazard()) begin
            st = 1; ld_shadow = 1;
        end else if (pif.dec_instr_v_i && pif.dec_mc_v_i) begin
            go = 1; mc_age = 0;
        end
        wdog_m = wd_n;
        want = ex(st, go, ab, fv, wd);
    endtask

    vec_t vecs[10];

    initial begin
        logic [6:0] want;
        clr_in();
        vecs[0] = '{1, 1, 5'd5, 0, 5'd0, 0, 1, 5'd5, 1, 0};  // rs1 == rd
        vecs[1] = '{1, 1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0};  // rd x0
        vecs[2] = '{1, 0, 5'd0, 1, 5'd9, 0, 1, 5'd9, 1, 0};  // rs2 == rd
        vecs[3] = '{1, 0, 5'd0, 0, 5'd9, 0, 1, 5'd9, 0, 0};  // rs2 match, not read
        vecs[4] = '{0, 1, 5'd5, 0, 5'd0, 0, 1, 5'd5, 0, 0};  // no DEC instr
        vecs[5] = '{1, 1, 5'd5, 0, 5'd0, 0, 0, 5'd5, 0, 0};  // EXE not a load
        vecs[6] = '{1, 1, 5'd3, 1, 5'd4, 1, 1, 5'd7, 0, 1};  // mc issue, no hazard
        vecs[7] = '{1, 1, 5'd7, 0, 5'd0, 1, 1, 5'd7, 1, 0};  // hazard beats mc issue
        vecs[8] = '{1, 1, 5'd6, 1, 5'd8, 0, 1, 5'd7, 0, 0};  // no match
        vecs[9] = '{0, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0};  // mc flag, no instr

        // Reset state: hazard inputs present while in reset must not leak out.
        reset_n = 1'b0;
        set_in(1, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5);
        #1;
        chk("reset_outs", outs(), 7'b0);
        do_reset();
        chk("post_reset", outs(), 7'b0);

        foreach (vecs[i]) begin
            do_reset();
            set_in(vecs[i].dv, vecs[i].r1v, vecs[i].r1, vecs[i].r2v, vecs[i].r2,
                   vecs[i].mcv, vecs[i].ldv, vecs[i].rd);
            #2;
            chk($sformatf("vec%0d", i), outs(),
                ex(vecs[i].exp_stall, vecs[i].exp_start, 0, 0, 0));
        end

        // Load-use: one stall cycle, one shadow cycle, then issue.
        do_reset();
        set_in(1, 1, 5'd5, 0, 5'd0, 0, 1, 5'd5);
        #2; chk("ld_stall", outs(), ex(1, 0, 0, 0, 0));
        tick(); #2; chk("ld_shadow", outs(), ex(0, 0, 0, 0, 0));
        tick(); set_in(1, 1, 5'd5, 0, 5'd0, 1, 0, 5'd0);
        #2; chk("ld_issue", outs(), ex(0, 1, 0, 0, 0));

        // Multi-cycle op finishing at cycle 7.
        do_reset();
        set_in(1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0);
        #2; chk("mc_start", outs(), ex(0, 1, 0, 0, 0));
        tick(); clr_in();
        for (int c = 1; c <= 6; c++) begin
            #2; chk($sformatf("mc_wait%0d", c), outs(), ex(1, 0, 0, 0, 0));
            tick();
        end
        pif.mc_done_i = 1'b1;
        #2; chk("mc_done", outs(), ex(0, 0, 0, 0, 0));
        tick(); pif.mc_done_i = 1'b0;
        set_in(1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0);
        #2; chk("mc_rerun", outs(), ex(0, 1, 0, 0, 0));

        // Watchdog: abort at the 8th wait cycle, sticky error until reset.
        do_reset();
        set_in(1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0);
        tick(); clr_in();
        for (int c = 1; c <= 7; c++) begin
            #2; chk($sformatf("wd_wait%0d", c), outs(), ex(1, 0, 0, 0, 0));
            tick();
        end
        #2; chk("wd_abort", outs(), ex(0, 0, 1, 0, 0));
        tick(); #2; chk("wd_err", outs(), ex(0, 0, 0, 0, 1));
        tick(); tick(); #2; chk("wd_sticky", outs(), ex(0, 0, 0, 0, 1));
        reset_n = 1'b0; #1;
        chk("wd_cleared", outs(), 7'b0);

        // Single flush, then a request re-arriving one cycle later.
        do_reset();
        set_in(1, 1, 5'd5, 0, 5'd0, 0, 1, 5'd5);
        pif.flush_req_i = 1'b1;
        #2; chk("fl_req", outs(), ex(0, 0, 0, 0, 0));
        tick(); pif.flush_req_i = 1'b0;
        #2; chk("fl_p1", outs(), ex(0, 0, 0, 1, 0));
        tick(); #2; chk("fl_p2", outs(), ex(0, 0, 0, 1, 0));
        tick(); clr_in(); #2; chk("fl_p3", outs(), ex(0, 0, 0, 0, 0));
        pif.flush_req_i = 1'b1;
        tick(); #2; chk("fl2_p1", outs(), ex(0, 0, 0, 1, 0));
        tick(); pif.flush_req_i = 1'b0;
        #2; chk("fl2_p2", outs(), ex(0, 0, 0, 1, 0));
        tick(); #2; chk("fl2_p3", outs(), ex(0, 0, 0, 1, 0));
        tick(); #2; chk("fl2_p4", outs(), ex(0, 0, 0, 0, 0));

        // Flush and done in the same MC_WAIT cycle: result discarded.
        do_reset();
        set_in(1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0);
        tick(); clr_in();
        tick();
        pif.flush_req_i = 1'b1; pif.mc_done_i = 1'b1;
        #2; chk("coll_abort", outs(), ex(0, 0, 1, 0, 0));
        tick(); pif.flush_req_i = 1'b0;
        #2; chk("coll_flush", outs(), ex(0, 0, 0, 1, 0));

        // Reset while waiting on the mc unit.
        do_reset();
        set_in(1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0);
        tick();
        #2; chk("rst_mc_wait", outs(), ex(1, 0, 0, 0, 0));
        reset_n = 1'b0; #1;
        chk("rst_mc_async", outs(), 7'b0);
        tick(); reset_n = 1'b1;
        #2; chk("rst_mc_run", outs(), ex(0, 1, 0, 0, 0));

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
            pif.mc_done_i   = ($urandom_range(0, 7) == 0);
            pif.flush_req_i = ($urandom_range(0, 19) == 0);
            #2;
            model_step(want);
            chk($sformatf("rand%0d", c), outs(), want);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
